// File: rtl/sum_averager_if.sv
// rtl/sum_averager_if.sv - sample-stream and block-average handshake bundle for sum_averager
interface sum_averager_if #(
    parameter int DATA_W = 16
);
    logic              src_valid;
    logic [DATA_W-1:0] sum_in;
    logic              avg_ready;
    logic              avg_valid;
    logic [DATA_W-1:0] avg_data;
    logic              overrun;

    // Producer/consumer side: feeds samples and accepts averages
    modport master (
        output src_valid,
        output sum_in,
        output avg_ready,
        input  avg_valid,
        input  avg_data,
        input  overrun
    );

    // Averager side
    modport slave (
        input  src_valid,
        input  sum_in,
        input  avg_ready,
        output avg_valid,
        output avg_data,
        output overrun
    );
endinterface

// File: rtl/sum_averager.sv
// rtl/sum_averager.sv - block averager for the pipelined adder sum stream; AVG_ROUND_EN selects round-half-up
module sum_averager #(
    parameter int DATA_W  = 16,
    parameter int LOG2_N  = 2,
    parameter int ADD_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sum_averager_if.slave bus
);
    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
`ifdef AVG_ROUND_EN
    localparam int RND   = (LOG2_N == 0) ? 0 : (N / 2);
`else
    localparam int RND   = 0;
`endif

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [ADD_LAT-1:0] vdly;
    logic               v_al;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               done;
    logic [ACC_W-1:0]   total;
    logic [DATA_W-1:0]  res;
    logic [0:0]         state;
    logic [DATA_W-1:0]  avg_q;
    logic               overrun_q;

    // Delay src_valid by the adder latency so it lines up with its sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vdly <= '0;
        end else begin
            vdly[0] <= bus.src_valid;
            for (int i = 1; i < ADD_LAT; i++) begin
                vdly[i] <= vdly[i-1];
            end
        end
    end

    assign v_al = vdly[ADD_LAT-1];

    // Block completion and the rounded/truncated average; the full block sum
    // plus rounding bias always fits in ACC_W bits
    always_comb begin
        total = acc + ACC_W'(bus.sum_in) + ACC_W'(RND);
        res   = DATA_W'(total >> LOG2_N);
        done  = v_al && (count == CNT_W'(N - 1));
    end

    // Accumulate aligned samples; restart on the block's last sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (v_al) begin
            if (done) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= acc + ACC_W'(bus.sum_in);
                count <= count + CNT_W'(1);
            end
        end
    end

    // Output holding register with drop-and-flag when the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            avg_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (done) begin
                        avg_q <= res;
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.avg_ready) begin
                        if (done) begin
                            avg_q <= res;
                        end else begin
                            state <= ST_ACC;
                        end
                    end else if (done) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign bus.avg_valid = (state == ST_OUT);
    assign bus.avg_data  = avg_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sum_averager.sv
// tb/tb_sum_averager.sv - directed self-checking bench for sum_averager
module tb_sum_averager;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;
    logic [15:0] hist [3];

    sum_averager_if #(.DATA_W(16)) bus ();

    sum_averager #(
        .DATA_W (16),
        .LOG2_N (2),
        .ADD_LAT(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: src_valid now, matching sum presented three cycles later
    task automatic step(input logic v, input logic [15:0] val);
        @(negedge clk);
        bus.sum_in    = hist[2];
        hist[2]       = hist[1];
        hist[1]       = hist[0];
        hist[0]       = v ? val : 16'($urandom);
        bus.src_valid = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic feed4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        step(1'b1, a);
        step(1'b1, b);
        step(1'b1, c);
        step(1'b1, d);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp3;
        n_cmp = 0;
        n_mis = 0;
        hist[0] = '0;
        hist[1] = '0;
        hist[2] = '0;
        bus.src_valid = 1'b0;
        bus.sum_in    = '0;
        bus.avg_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(bus.avg_valid), 32'd0);
        check_eq("rst_data", 32'(bus.avg_data), 32'd0);
        check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
        rst_n = 1'b1;

        // 1: junk on sum_in with src_valid low produces nothing
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.sum_in = 16'($urandom);
        end
        check_eq("idle_valid", 32'(bus.avg_valid), 32'd0);
        check_eq("idle_overrun", 32'(bus.overrun), 32'd0);

        // 2: 10,20,30,40 -> 25 for exactly one cycle
        feed4(16'd10, 16'd20, 16'd30, 16'd40);
        idle(3);
        check_eq("blk1_early", 32'(bus.avg_valid), 32'd0);
        idle(1);
        check_eq("blk1_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("blk1_data", 32'(bus.avg_data), 32'd25);
        idle(1);
        check_eq("blk1_drop", 32'(bus.avg_valid), 32'd0);

        // 3: 1,2,2,2 -> 1 truncated, 2 rounded
`ifdef AVG_ROUND_EN
        exp3 = 16'd2;
`else
        exp3 = 16'd1;
`endif
        feed4(16'd1, 16'd2, 16'd2, 16'd2);
        idle(4);
        check_eq("rnd_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("rnd_data", 32'(bus.avg_data), 32'(exp3));

        // 4: full-scale samples must not overflow
        feed4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        idle(4);
        check_eq("max_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("max_data", 32'(bus.avg_data), 32'hFFFF);
        idle(1);

        // gapped src_valid: 5,9,11,15 -> 10
        step(1'b1, 16'd5);
        idle(1);
        step(1'b1, 16'd9);
        idle(2);
        step(1'b1, 16'd11);
        step(1'b1, 16'd15);
        idle(4);
        check_eq("gap_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("gap_data", 32'(bus.avg_data), 32'd10);
        idle(1);
        check_eq("overrun_clean", 32'(bus.overrun), 32'd0);

        // 5: consumer stalled, second block dropped
        bus.avg_ready = 1'b0;
        feed4(16'd10, 16'd20, 16'd30, 16'd40);
        feed4(16'd7, 16'd7, 16'd7, 16'd7);
        idle(4);
        check_eq("ovr_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("ovr_data", 32'(bus.avg_data), 32'd25);
        check_eq("ovr_flag", 32'(bus.overrun), 32'd1);
        bus.avg_ready = 1'b1;
        idle(1);
        check_eq("ovr_hs_valid", 32'(bus.avg_valid), 32'd0);
        check_eq("ovr_sticky", 32'(bus.overrun), 32'd1);

        // back-to-back blocks with ready high: second replaces first
        feed4(16'd4, 16'd4, 16'd4, 16'd4);
        feed4(16'd8, 16'd8, 16'd8, 16'd8);
        idle(3);
        check_eq("b2b_first", 32'(bus.avg_data), 32'd4);
        idle(1);
        check_eq("b2b_second", 32'(bus.avg_data), 32'd8);
        check_eq("b2b_valid", 32'(bus.avg_valid), 32'd1);
        idle(1);

        // 6: partial block discarded by reset
        step(1'b1, 16'd100);
        step(1'b1, 16'd100);
        idle(4);
        pulse_reset();
        check_eq("rst2_overrun", 32'(bus.overrun), 32'd0);
        check_eq("rst2_valid", 32'(bus.avg_valid), 32'd0);
        feed4(16'd4, 16'd4, 16'd8, 16'd8);
        idle(4);
        check_eq("post_rst_valid", 32'(bus.avg_valid), 32'd1);
        check_eq("post_rst_data", 32'(bus.avg_data), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
